// File: rtl/ser_pkg.sv
`default_nettype none
// ============================================================================
// Module      : ser_pkg
// Description : Shared types and helpers for the bit serializer: FSM state
//               encoding, default word width and a counter-width function.
// Revision    : 1.0 - initial release
// ============================================================================
package ser_pkg;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_GAP   = 2'd2
  } ser_state_e;

  localparam int SER_WIDTH_DEF = 8;

  // Bits needed to index 0..value-1; never less than 1 so a WIDTH=1 word
  // still gets a legal one-bit counter.
  function automatic int clog2(input int value);
    int res;
    int v;
    res = 0;
    v   = value - 1;
    while (v > 0) begin
      res = res + 1;
      v   = v >> 1;
    end
    return (res < 1) ? 1 : res;
  endfunction

endpackage
`default_nettype wire

// File: rtl/bit_serializer_if.sv
`default_nettype none
// ============================================================================
// Module      : bit_serializer_if
// Description : Parallel-word handshake and serial output bundle of the bit
//               serializer. slave = serializer side, master = feeder/observer.
// Revision    : 1.0 - initial release
// ============================================================================
interface bit_serializer_if
  import ser_pkg::*;
#(
  parameter int WIDTH = SER_WIDTH_DEF
);
  logic [WIDTH-1:0] in_data;
  logic             in_valid;
  logic             in_ready;
  logic             dout;
  logic             dout_valid;
  logic             word_done;
  logic             busy;

  modport master (
    output in_data, in_valid,
    input  in_ready, dout, dout_valid, word_done, busy
  );

  modport slave (
    input  in_data, in_valid,
    output in_ready, dout, dout_valid, word_done, busy
  );
endinterface
`default_nettype wire

// File: rtl/ser_hold_buf.sv
`default_nettype none
// ============================================================================
// Module      : ser_hold_buf
// Description : One-entry holding register parking the next word while the
//               shift register is still busy. rst is asynchronous, active-low.
// Revision    : 1.0 - initial release
// ============================================================================
module ser_hold_buf
  import ser_pkg::*;
#(
  parameter int WIDTH = SER_WIDTH_DEF
) (
  input  wire logic             clk,
  input  wire logic             rst,
  input  wire logic             load,
  input  wire logic             unload,
  input  wire logic [WIDTH-1:0] din,
  output logic      [WIDTH-1:0] dout,
  output logic                  full
);
  logic [WIDTH-1:0] data_q, data_d;
  logic             full_q, full_d;

  // Next contents: a load wins over an unload (they never coincide in use).
  always_comb begin
    data_d = data_q;
    full_d = full_q;
    if (unload) full_d = 1'b0;
    if (load) begin
      data_d = din;
      full_d = 1'b1;
    end
  end

  // Storage, emptied by reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      data_q <= '0;
      full_q <= 1'b0;
    end else begin
      data_q <= data_d;
      full_q <= full_d;
    end
  end

  assign dout = data_q;
  assign full = full_q;
endmodule
`default_nettype wire

// File: rtl/bit_serializer.sv
`default_nettype none
// ============================================================================
// Module      : bit_serializer
// Description : Serializes parallel words one bit per clk, MSB or LSB first,
//               with a one-word holding buffer so consecutive words stream
//               without a bubble. Optional macro SER_GAP_EN inserts one
//               dout=0/dout_valid=1 gap cycle after every word.
//               rst is asynchronous, active-low. All outputs registered.
// Revision    : 1.0 - initial release
// ============================================================================
module bit_serializer
  import ser_pkg::*;
#(
  parameter int WIDTH     = SER_WIDTH_DEF,
  parameter int MSB_FIRST = 1
) (
  input wire logic         clk,
  input wire logic         rst,
  bit_serializer_if.slave  bus
);
  localparam int             CNT_W    = clog2(WIDTH);
  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(WIDTH - 1);
`ifdef SER_GAP_EN
  localparam bit GAP_EN = 1'b1;
`else
  localparam bit GAP_EN = 1'b0;
`endif

  // Bit presented first from a word, and the word with that bit consumed.
  function automatic logic first_bit(input logic [WIDTH-1:0] w);
    return (MSB_FIRST != 0) ? w[WIDTH-1] : w[0];
  endfunction

  function automatic logic [WIDTH-1:0] advance(input logic [WIDTH-1:0] w);
    return (MSB_FIRST != 0) ? (w << 1) : (w >> 1);
  endfunction

  ser_state_e       state_q, state_d;
  logic [WIDTH-1:0] sh_q, sh_d;          // bits still to be sent after dout_q
  logic [CNT_W-1:0] cnt_q, cnt_d;        // index of the bit now on dout
  logic             dout_q, dout_d;
  logic             dout_valid_q, dout_valid_d;
  logic             word_done_q, word_done_d;
  logic             in_ready_q, in_ready_d;
  logic             busy_q, busy_d;

  logic             accept;
  logic             last_bit;
  logic             load_now;
  logic [WIDTH-1:0] load_word;
  logic             hold_load, hold_unload, hold_full, hold_full_d;
  logic [WIDTH-1:0] hold_data;

  // in_ready_q mirrors the buffer being empty, so it never depends on in_valid.
  assign accept   = bus.in_valid & in_ready_q;
  assign last_bit = (state_q == S_SHIFT) && (cnt_q == LAST_IDX);

  ser_hold_buf #(
    .WIDTH (WIDTH)
  ) u_hold (
    .clk    (clk),
    .rst    (rst),
    .load   (hold_load),
    .unload (hold_unload),
    .din    (bus.in_data),
    .dout   (hold_data),
    .full   (hold_full)
  );

  // FSM next state and next registered outputs; a word is loaded into the
  // shift register either straight from the bus or from the holding buffer.
  always_comb begin
    state_d      = state_q;
    sh_d         = sh_q;
    cnt_d        = cnt_q;
    dout_d       = 1'b0;
    dout_valid_d = 1'b0;
    word_done_d  = 1'b0;
    hold_load    = 1'b0;
    hold_unload  = 1'b0;
    load_now     = 1'b0;
    load_word    = bus.in_data;

    case (state_q)
      S_IDLE: begin
        if (accept) load_now = 1'b1;
      end
      S_SHIFT: begin
        if (!last_bit) begin
          dout_d       = first_bit(sh_q);
          sh_d         = advance(sh_q);
          cnt_d        = cnt_q + 1'b1;
          dout_valid_d = 1'b1;
          word_done_d  = ((cnt_q + 1'b1) == LAST_IDX);
          hold_load    = accept;
        end else if (GAP_EN) begin
          // Separator bit: a word arriving now waits in the buffer.
          state_d      = S_GAP;
          dout_valid_d = 1'b1;
          hold_load    = accept;
        end else if (hold_full) begin
          hold_unload = 1'b1;
          load_now    = 1'b1;
          load_word   = hold_data;
        end else if (accept) begin
          load_now = 1'b1;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_GAP: begin
        if (hold_full) begin
          hold_unload = 1'b1;
          load_now    = 1'b1;
          load_word   = hold_data;
        end else if (accept) begin
          load_now = 1'b1;
        end else begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase

    if (load_now) begin
      state_d      = S_SHIFT;
      dout_d       = first_bit(load_word);
      sh_d         = advance(load_word);
      cnt_d        = '0;
      dout_valid_d = 1'b1;
      word_done_d  = (LAST_IDX == '0);
    end

    hold_full_d = (hold_full & ~hold_unload) | hold_load;
    in_ready_d  = ~hold_full_d;
    busy_d      = (state_d != S_IDLE) | hold_full_d;
  end

  // State and output registers; reset discards any word in flight.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= S_IDLE;
      sh_q         <= '0;
      cnt_q        <= '0;
      dout_q       <= 1'b0;
      dout_valid_q <= 1'b0;
      word_done_q  <= 1'b0;
      in_ready_q   <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      sh_q         <= sh_d;
      cnt_q        <= cnt_d;
      dout_q       <= dout_d;
      dout_valid_q <= dout_valid_d;
      word_done_q  <= word_done_d;
      in_ready_q   <= in_ready_d;
      busy_q       <= busy_d;
    end
  end

  assign bus.in_ready   = in_ready_q;
  assign bus.dout       = dout_q;
  assign bus.dout_valid = dout_valid_q;
  assign bus.word_done  = word_done_q;
  assign bus.busy       = busy_q;
endmodule
`default_nettype wire

// File: tb/tb_bit_serializer.sv
`default_nettype none
// ============================================================================
// Module      : tb_bit_serializer
// Description : Directed self-checking bench for bit_serializer (WIDTH=8,
//               MSB first). Expected streams follow SER_GAP_EN when defined.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_bit_serializer;
  logic clk;
  logic rst;
  int   n_checks;
  int   n_fail;

  bit_serializer_if #(.WIDTH(8)) bif ();

  bit_serializer #(
    .WIDTH     (8),
    .MSB_FIRST (1)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bif)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      $error("%s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Offers nw words back to back (in_valid held while words remain) and
  // checks n cycles of output against expected vectors, cycle i at bit n-1-i.
  task automatic run_stream(input string tag,
                            input logic [7:0] w0, input logic [7:0] w1, input logic [7:0] w2,
                            input int nw, input int n,
                            input logic [31:0] e_dout, input logic [31:0] e_wd,
                            input logic [31:0] e_rdy, input int e_runs);
    logic [7:0] wq [3];
    int   k;
    int   runs;
    logic rdy;
    logic prev;
    logic cur;
    wq[0] = w0; wq[1] = w1; wq[2] = w2;
    k = 0; runs = 0; prev = 1'b0;
    bif.in_data  = w0;
    bif.in_valid = 1'b1;
    for (int i = 0; i < n; i++) begin
      rdy = bif.in_ready;
      step();
      if (bif.in_valid && rdy) k++;
      if (k < nw) begin
        bif.in_data  = wq[k];
        bif.in_valid = 1'b1;
      end else begin
        bif.in_valid = 1'b0;
      end
      check($sformatf("%s dout[%0d]", tag, i), 32'(bif.dout), 32'(e_dout[n-1-i]));
      check($sformatf("%s dout_valid[%0d]", tag, i), 32'(bif.dout_valid), 32'd1);
      check($sformatf("%s word_done[%0d]", tag, i), 32'(bif.word_done), 32'(e_wd[n-1-i]));
      check($sformatf("%s in_ready[%0d]", tag, i), 32'(bif.in_ready), 32'(e_rdy[n-1-i]));
      check($sformatf("%s busy[%0d]", tag, i), 32'(bif.busy), 32'd1);
      cur = bif.dout & bif.dout_valid;
      if (cur && !prev) runs++;
      prev = cur;
    end
    step();
    check({tag, " idle dout_valid"}, 32'(bif.dout_valid), 32'd0);
    check({tag, " idle dout"}, 32'(bif.dout), 32'd0);
    check({tag, " idle busy"}, 32'(bif.busy), 32'd0);
    check({tag, " words accepted"}, 32'(k), 32'(nw));
    check({tag, " runs of ones"}, 32'(runs), 32'(e_runs));
  endtask

  initial begin
    logic [7:0] w6;
    n_checks = 0;
    n_fail   = 0;

    // Reset held with in_valid asserted.
    rst          = 1'b0;
    bif.in_valid = 1'b1;
    bif.in_data  = 8'h55;
    step();
    step();
    check("reset dout", 32'(bif.dout), 32'd0);
    check("reset dout_valid", 32'(bif.dout_valid), 32'd0);
    check("reset word_done", 32'(bif.word_done), 32'd0);
    check("reset in_ready", 32'(bif.in_ready), 32'd0);
    check("reset busy", 32'(bif.busy), 32'd0);
    rst          = 1'b1;
    bif.in_valid = 1'b0;
    step();
    check("post-reset in_ready", 32'(bif.in_ready), 32'd1);
    check("post-reset busy", 32'(bif.busy), 32'd0);
    check("post-reset dout_valid", 32'(bif.dout_valid), 32'd0);

`ifdef SER_GAP_EN
    run_stream("single", 8'hF0, 8'h00, 8'h00, 1, 9,
               {8'hF0, 1'b0}, {8'h01, 1'b0}, {8'hFF, 1'b1}, 1);
    run_stream("b2b", 8'hFF, 8'hFF, 8'h00, 2, 18,
               {8'hFF, 1'b0, 8'hFF, 1'b0}, {8'h01, 1'b0, 8'h01, 1'b0},
               {8'h80, 1'b0, 8'hFF, 1'b1}, 2);
    run_stream("bkpr", 8'hC3, 8'h5A, 8'h96, 3, 27,
               {8'hC3, 1'b0, 8'h5A, 1'b0, 8'h96, 1'b0},
               {8'h01, 1'b0, 8'h01, 1'b0, 8'h01, 1'b0},
               {8'h80, 1'b0, 8'h80, 1'b0, 8'hFF, 1'b1}, 8);
`else
    run_stream("single", 8'hF0, 8'h00, 8'h00, 1, 8,
               32'hF0, 32'h01, 32'hFF, 1);
    run_stream("b2b", 8'hFF, 8'hFF, 8'h00, 2, 16,
               {8'hFF, 8'hFF}, {8'h01, 8'h01}, {8'h80, 8'hFF}, 1);
    run_stream("bkpr", 8'hC3, 8'h5A, 8'h96, 3, 24,
               {8'hC3, 8'h5A, 8'h96}, {8'h01, 8'h01, 8'h01},
               {8'h80, 8'h80, 8'hFF}, 8);
`endif

    // Reset in the middle of 8'hA5, while bit 3 is on dout.
    w6           = 8'hA5;
    bif.in_data  = w6;
    bif.in_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step();
      bif.in_valid = 1'b0;
      check($sformatf("a5 dout[%0d]", i), 32'(bif.dout), 32'(w6[7-i]));
    end
    rst = 1'b0;
    #1;
    check("midrst dout", 32'(bif.dout), 32'd0);
    check("midrst dout_valid", 32'(bif.dout_valid), 32'd0);
    check("midrst busy", 32'(bif.busy), 32'd0);
    check("midrst in_ready", 32'(bif.in_ready), 32'd0);
    step();
    rst = 1'b1;
    step();
    check("midrst release in_ready", 32'(bif.in_ready), 32'd1);
    check("midrst release dout_valid", 32'(bif.dout_valid), 32'd0);

`ifdef SER_GAP_EN
    run_stream("after-rst", 8'h81, 8'h00, 8'h00, 1, 9,
               {8'h81, 1'b0}, {8'h01, 1'b0}, {8'hFF, 1'b1}, 2);
`else
    run_stream("after-rst", 8'h81, 8'h00, 8'h00, 1, 8,
               32'h81, 32'h01, 32'hFF, 2);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
`default_nettype wire
